// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM-state definitions for the registered sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_ADC = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath for the sequential ALU: one-bit-per-cycle left shift
// and LSB-first shift-add multiply, sharing one accumulator and step counter.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             isMul_i,
    input  logic [WIDTH-1:0] opA_i,
    input  logic [WIDTH-1:0] opB_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic [SHW:0]     count_o,
    output logic [WIDTH-1:0] stepResult_o,
    output logic             stepCarry_o
);

    localparam int CW = SHW + 1;

    logic               mulQ;
    logic [CW-1:0]      countQ;
    logic [2*WIDTH-1:0] accQ;
    logic [2*WIDTH-1:0] accD;
    logic [2*WIDTH-1:0] mcandQ;
    logic [WIDTH-1:0]   mplierQ;

    // The outputs describe the value after the current step, so the top can
    // load Result on the same edge that performs the final step.
    always_comb begin
        accD        = '0;
        stepCarry_o = 1'b0;
        if (mulQ) begin
            accD        = accQ + (mplierQ[0] ? mcandQ : '0);
            stepCarry_o = |accD[2*WIDTH-1:WIDTH];
        end else begin
            accD        = accQ << 1;
            stepCarry_o = accQ[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mulQ    <= 1'b0;
            countQ  <= '0;
            accQ    <= '0;
            mcandQ  <= '0;
            mplierQ <= '0;
        end else if (load_i) begin
            mulQ    <= isMul_i;
            countQ  <= isMul_i ? CW'(WIDTH) : CW'(shamt_i);
            accQ    <= isMul_i ? '0 : {{WIDTH{1'b0}}, opA_i};
            mcandQ  <= {{WIDTH{1'b0}}, opA_i};
            mplierQ <= opB_i;
        end else if (step_i) begin
            accQ    <= accD;
            mcandQ  <= mcandQ << 1;
            mplierQ <= mplierQ >> 1;
            countQ  <= countQ - CW'(1);
        end
    end

    assign count_o      = countQ;
    assign stepResult_o = accD[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with Start/Done handshake; single-cycle ops resolve here,
// shifts by a nonzero amount and multiplies run in seq_alu_iter.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUSelect,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             C,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam int CW = SHW + 1;

    state_e           stateQ, stateD;
    logic [WIDTH-1:0] resultQ, resultD;
    logic             cQ, cD, zQ, zD, nQ, nD, vQ, vD;
    logic             loadRes;
    logic             iterLoad, iterStep;
    logic [CW-1:0]    iterCount;
    logic [WIDTH-1:0] iterResult;
    logic             iterCarry;
    logic [WIDTH:0]   addSum, subSum;
    logic [SHW-1:0]   shamt;
    logic             goIter;

    assign shamt  = B[SHW-1:0];
    assign addSum = {1'b0, A} + {1'b0, B}
                  + {{WIDTH{1'b0}}, (ALUSelect == OP_ADC) & cQ};
    assign subSum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign goIter = (ALUSelect == OP_MUL) || ((ALUSelect == OP_SHL) && (shamt != '0));

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk          (clk),
        .reset        (reset),
        .load_i       (iterLoad),
        .step_i       (iterStep),
        .isMul_i      (ALUSelect == OP_MUL),
        .opA_i        (A),
        .opB_i        (B),
        .shamt_i      (shamt),
        .count_o      (iterCount),
        .stepResult_o (iterResult),
        .stepCarry_o  (iterCarry)
    );

    // Result and flags are only committed on the edge that enters DONE.
    always_comb begin
        stateD   = stateQ;
        iterLoad = 1'b0;
        iterStep = 1'b0;
        loadRes  = 1'b0;
        resultD  = resultQ;
        cD       = cQ;
        vD       = vQ;
        case (stateQ)
            ST_IDLE: begin
                if (Start) begin
                    if (goIter) begin
                        iterLoad = 1'b1;
                        stateD   = ST_EXEC;
                    end else begin
                        loadRes = 1'b1;
                        stateD  = ST_DONE;
                        cD      = 1'b0;
                        vD      = 1'b0;
                        case (ALUSelect)
                            OP_ADD, OP_ADC: begin
                                resultD = addSum[WIDTH-1:0];
                                cD      = addSum[WIDTH];
                                vD      = (A[WIDTH-1] == B[WIDTH-1]) &&
                                          (addSum[WIDTH-1] != A[WIDTH-1]);
                            end
                            OP_SUB: begin
                                resultD = subSum[WIDTH-1:0];
                                cD      = subSum[WIDTH];
                                vD      = (A[WIDTH-1] != B[WIDTH-1]) &&
                                          (subSum[WIDTH-1] != A[WIDTH-1]);
                            end
                            OP_AND:  resultD = A & B;
                            OP_XOR:  resultD = A ^ B;
                            OP_OR:   resultD = A | B;
                            default: resultD = A;
                        endcase
                    end
                end
            end
            ST_EXEC: begin
                iterStep = 1'b1;
                if (iterCount == CW'(1)) begin
                    loadRes = 1'b1;
                    stateD  = ST_DONE;
                    resultD = iterResult;
                    cD      = iterCarry;
                    vD      = 1'b0;
                end
            end
            ST_DONE: stateD = ST_IDLE;
            default: stateD = ST_IDLE;
        endcase
        zD = (resultD == '0);
        nD = resultD[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= ST_IDLE;
            resultQ <= '0;
            cQ      <= 1'b0;
            zQ      <= 1'b0;
            nQ      <= 1'b0;
            vQ      <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (loadRes) begin
                resultQ <= resultD;
                cQ      <= cD;
                zQ      <= zD;
                nQ      <= nD;
                vQ      <= vD;
            end
        end
    end

    assign Busy   = (stateQ == ST_EXEC);
    assign Done   = (stateQ == ST_DONE);
    assign Result = resultQ;
    assign C      = cQ;
    assign Z      = zQ;
    assign N      = nQ;
    assign V      = vQ;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes hand-computed responses,
// a negedge monitor pops and compares them whenever Done is seen.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [W-1:0] A, B;
    logic [2:0]   ALUSelect;
    logic         Busy, Done;
    logic [W-1:0] Result;
    logic         C, Z, N, V;

    typedef struct {
        logic [W-1:0] res;
        logic         c, z, n, v;
        int           lat;
        int           busy;
        int           startCyc;
        string        name;
    } exp_t;

    exp_t         sbQ[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           busyCnt  = 0;
    logic [W-1:0] lastRes;
    logic         lastC, lastZ, lastN, lastV;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .ALUSelect (ALUSelect),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .C         (C),
        .Z         (Z),
        .N         (N),
        .V         (V)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busyCnt = 0;
        end else begin
            if (Busy) busyCnt++;
            if (Done) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'(Done), 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.name, "_result"}, 32'(Result), 32'(e.res));
                    checkOutput({e.name, "_flagsCZNV"}, 32'({C, Z, N, V}),
                                32'({e.c, e.z, e.n, e.v}));
                    checkOutput({e.name, "_latency"}, 32'(cyc - e.startCyc), 32'(e.lat));
                    checkOutput({e.name, "_busyCycles"}, 32'(busyCnt), 32'(e.busy));
                end
                busyCnt = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] expRes,
                                 input logic expC, input logic expZ, input logic expN,
                                 input logic expV, input int expLat, input int expBusy,
                                 input int midCycle, input string name);
        exp_t e;
        @(negedge clk); #1;
        Start     = 1'b1;
        A         = a;
        B         = b;
        ALUSelect = op;
        e.res = expRes; e.c = expC; e.z = expZ; e.n = expN; e.v = expV;
        e.lat = expLat; e.busy = expBusy; e.startCyc = cyc; e.name = name;
        sbQ.push_back(e);
        @(negedge clk); #1;
        Start     = 1'b0;
        A         = ~a;
        B         = ~b;
        ALUSelect = ~op;
        for (int i = 1; i <= 60; i++) begin
            if (sbQ.size() == 0) break;
            if (midCycle != 0 && i == midCycle) begin
                checkOutput({name, "_holdResult"}, 32'(Result), 32'(lastRes));
                checkOutput({name, "_holdFlags"}, 32'({C, Z, N, V}),
                            32'({lastC, lastZ, lastN, lastV}));
                Start     = 1'b1;
                A         = 16'hFFFF;
                B         = 16'h0001;
                ALUSelect = OP_ADD;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk); #1;
        end
        Start = 1'b0;
        if (sbQ.size() != 0) begin
            checkOutput({name, "_timeout"}, 32'(sbQ.size()), 32'd0);
            sbQ.delete();
        end
        lastRes = expRes; lastC = expC; lastZ = expZ; lastN = expN; lastV = expV;
    endtask

    initial begin
        reset     = 1'b1;
        Start     = 1'b0;
        A         = '0;
        B         = '0;
        ALUSelect = '0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        checkOutput("reset_result", 32'(Result), 32'd0);
        checkOutput("reset_ctrlFlags", 32'({Busy, Done, C, Z, N, V}), 32'd0);

        applyStimulus(OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 1, 0, 1, 0, 0, "sub_pre");

        // Abort an in-flight multiply with reset; it must never report Done.
        @(negedge clk); #1;
        Start = 1'b1; A = 16'h0003; B = 16'h0005; ALUSelect = OP_MUL;
        @(negedge clk); #1;
        Start = 1'b0;
        repeat (4) @(negedge clk);
        #1 checkOutput("abort_busyBeforeReset", 32'(Busy), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        checkOutput("abort_result", 32'(Result), 32'd0);
        checkOutput("abort_ctrlFlags", 32'({Busy, Done, C, Z, N, V}), 32'd0);
        lastRes = '0; lastC = 0; lastZ = 0; lastN = 0; lastV = 0;
        repeat (20) @(negedge clk);

        applyStimulus(OP_ADD, 16'h0003, 16'h0004, 16'h0007, 0, 0, 0, 0, 1, 0, 0, "add_3_4");
        applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0, 1, 0, 0, "add_carry");
        applyStimulus(OP_ADC, 16'h0001, 16'h0001, 16'h0003, 0, 0, 0, 0, 1, 0, 0, "adc_cin");
        applyStimulus(OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 1, 0, 1, 0, 0, "sub_borrow");
        applyStimulus(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1, 1, 0, 0, "add_ovf");
        applyStimulus(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 0, 1, 1, 0, 0, "sub_ovf");
        applyStimulus(OP_SHL, 16'h8001, 16'h0001, 16'h0002, 1, 0, 0, 0, 2, 1, 0, "shl_1");
        applyStimulus(OP_SHL, 16'h1234, 16'h0004, 16'h2340, 1, 0, 0, 0, 5, 4, 0, "shl_4");
        applyStimulus(OP_SHL, 16'hABCD, 16'h0010, 16'hABCD, 0, 0, 1, 0, 1, 0, 0, "shl_0");
        applyStimulus(OP_SHL, 16'h0001, 16'h000F, 16'h8000, 0, 0, 1, 0, 16, 15, 0, "shl_15");
        applyStimulus(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 0, 17, 16, 5, "mul_ovf");
        applyStimulus(OP_MUL, 16'h0012, 16'h0034, 16'h03A8, 0, 0, 0, 0, 17, 16, 8, "mul_small");
        applyStimulus(OP_SUB, 16'h0007, 16'h0005, 16'h0002, 1, 0, 0, 0, 1, 0, 0, "sub_noborrow");
        applyStimulus(OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 1, 0, 1, 0, 0, "and");
        applyStimulus(OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 0, 1, 0, 0, 1, 0, 0, "xor");
        applyStimulus(OP_OR,  16'h0F0F, 16'h00F0, 16'h0FFF, 0, 0, 0, 0, 1, 0, 0, "or");

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
